// File: rtl/mem_port_arbiter.sv
// Arbitrates IF and MEM-stage requests onto one req/ack word memory; IF is protected from data-side starvation.
// Latency: request sampled in IDLE -> mem_req next cycle -> ready the cycle after ack. Requesters are stalled until ready.
module mem_port_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_ready,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              err_misaligned,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [8:0] WD_LIMIT   = 9'(TIMEOUT);

  state_t      state, next_state;
  logic        owner_dm;
  logic [3:0]  streak;
  logic [7:0]  wd;
  logic [8:0]  wd_inc;
  logic        sel_dm, start, misal, done_ack, done_to;
  logic        resp_dm;
  logic [31:0] sel_addr, resp_data;
  logic        unused_addr_bits;

  assign stall = (if_req & ~if_ready) | (dm_req & ~dm_ready);
  assign unused_addr_bits = ^sel_addr[31:ADDR_W+2];

  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    start      = 1'b0;
    misal      = 1'b0;
    done_ack   = 1'b0;
    done_to    = 1'b0;
    // IF wins a tie only once the data side has won STARVE_LIMIT times in a row against it.
    sel_dm     = dm_req & ~(if_req && (STARVE_LIMIT != 0) && (streak == STARVE_MAX));
    sel_addr   = sel_dm ? dm_addr : if_addr;
    wd_inc     = {1'b0, wd} + 9'd1;
    case (state)
      IDLE: begin
        if (if_req || dm_req) begin
          if (sel_addr[1:0] != 2'b00) begin
            misal      = 1'b1;
            next_state = RESP;
          end else begin
            start      = 1'b1;
            next_state = BUSY;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done_ack   = 1'b1;
          next_state = RESP;
        end else if ((TIMEOUT != 0) && (wd_inc == WD_LIMIT)) begin
          done_to    = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    resp_dm   = misal ? sel_dm : owner_dm;
    resp_data = misal   ? 32'h0 :
                done_to ? 32'hDEADBEEF :
                mem_we  ? 32'h0 : mem_rdata;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      owner_dm       <= 1'b0;
      streak         <= 4'd0;
      wd             <= 8'd0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= 32'h0;
      if_ready       <= 1'b0;
      dm_ready       <= 1'b0;
      if_rdata       <= 32'h0;
      dm_rdata       <= 32'h0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      if_ready       <= 1'b0;
      dm_ready       <= 1'b0;
      err_misaligned <= 1'b0;
      err_timeout    <= 1'b0;
      if (state == IDLE && (if_req || dm_req)) begin
        owner_dm <= sel_dm;
        if (sel_dm && if_req) streak <= (streak == 4'd15) ? 4'd15 : streak + 4'd1;
        else                  streak <= 4'd0;
      end
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= sel_dm & dm_we;
        mem_addr  <= sel_addr[ADDR_W+1:2];
        mem_wdata <= sel_dm ? dm_wdata : 32'h0;
        wd        <= 8'd0;
      end
      if (state == BUSY) wd <= wd + 8'd1;
      if (misal || done_ack || done_to) begin
        mem_req        <= 1'b0;
        err_misaligned <= misal;
        err_timeout    <= done_to;
        if (resp_dm) begin
          dm_ready <= 1'b1;
          dm_rdata <= resp_data;
        end else begin
          if_ready <= 1'b1;
          if_rdata <= resp_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: driver pushes expected completions, a monitor pops them on each ready pulse.
module tb_mem_port_arbiter;

  logic        clock, reset_n;
  logic        if_req, if_ready;
  logic [31:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_ready;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        err_misaligned, err_timeout;

  logic        ack_auto, ack_force;
  logic [31:0] mem [0:1023];

  typedef struct packed {
    logic        is_dm;
    logic [31:0] rdata;
    logic        err_mis;
    logic        err_to;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp, mon_got;
  int   checks = 0;
  int   errors = 0;

  mem_port_arbiter #(.ADDR_W(10), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .err_misaligned(err_misaligned), .err_timeout(err_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Zero-wait memory model with manual ack injection.
  assign mem_ack   = (ack_auto & mem_req) | ack_force;
  assign mem_rdata = mem[mem_addr];
  always @(posedge clock) if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_ready(input logic want_dm, output int cyc);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (want_dm ? dm_ready : if_ready) begin
        cyc = i;
        return;
      end
    end
    errors++;
    $display("FAIL ready_timeout: no %s ready within 40 cycles", want_dm ? "dm" : "if");
  endtask

  always @(negedge clock) begin
    if (if_ready && dm_ready) begin
      errors++;
      $display("FAIL both_ready: if_ready=1 dm_ready=1, required at most one");
    end else if (if_ready || dm_ready) begin
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: if_ready=%0b dm_ready=%0b, none required", if_ready, dm_ready);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_got = '{dm_ready, dm_ready ? dm_rdata : if_rdata, err_misaligned, err_timeout};
        checks++;
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL completion: got dm=%0b rdata=%h mis=%0b to=%0b, required dm=%0b rdata=%h mis=%0b to=%0b",
                   mon_got.is_dm, mon_got.rdata, mon_got.err_mis, mon_got.err_to,
                   mon_exp.is_dm, mon_exp.rdata, mon_exp.err_mis, mon_exp.err_to);
        end
      end
    end else if (err_misaligned || err_timeout) begin
      errors++;
      $display("FAIL stray_err: mis=%0b to=%0b without ready", err_misaligned, err_timeout);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, n, last, cnt;
    logic seen;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[4] = 32'h8C010004;
    reset_n = 1'b0; ack_auto = 1'b1; ack_force = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
    repeat (3) @(negedge clock);
    chk("reset_ctl", {if_ready, dm_ready, mem_req, mem_we, mem_addr, err_misaligned, err_timeout, stall}, 128'h0);
    chk("reset_data", {mem_wdata, if_rdata, dm_rdata}, 128'h0);
    reset_n = 1'b1;
    @(negedge clock);

    // Lone fetch
    if_addr = 32'h10; if_req = 1'b1;
    exp_q.push_back(exp_t'{1'b0, 32'h8C010004, 1'b0, 1'b0});
    #1 chk("fetch_stall_c0", stall, 1);
    @(negedge clock);
    chk("fetch_mem", {mem_req, mem_we, mem_addr, stall}, {1'b1, 1'b0, 10'd4, 1'b1});
    @(negedge clock);
    chk("fetch_ready_c2", {if_ready, stall}, {1'b1, 1'b0});
    if_req = 1'b0;
    @(negedge clock);

    // Store then load
    dm_we = 1'b1; dm_addr = 32'h20; dm_wdata = 32'hAB; dm_req = 1'b1;
    exp_q.push_back(exp_t'{1'b1, 32'h0, 1'b0, 1'b0});
    @(negedge clock);
    chk("sw_mem", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 10'd8, 32'hAB});
    wait_ready(1'b1, cyc);
    dm_req = 1'b0;
    @(negedge clock);
    chk("sw_written", mem[8], 32'hAB);
    dm_we = 1'b0; dm_req = 1'b1;
    exp_q.push_back(exp_t'{1'b1, 32'hAB, 1'b0, 1'b0});
    wait_ready(1'b1, cyc);
    dm_req = 1'b0;
    chk("lw_latency", cyc, 2);
    @(negedge clock);

    // Contention: DM x4, IF, DM
    if_addr = 32'h10; if_req = 1'b1;
    dm_we = 1'b0; dm_addr = 32'h20; dm_req = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_t'{1'b1, 32'hAB, 1'b0, 1'b0});
    exp_q.push_back(exp_t'{1'b0, 32'h8C010004, 1'b0, 1'b0});
    exp_q.push_back(exp_t'{1'b1, 32'hAB, 1'b0, 1'b0});
    n = 0; last = 0;
    for (int i = 1; i <= 60 && n < 6; i++) begin
      @(negedge clock);
      if (if_ready || dm_ready) begin
        n++;
        last = i;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    chk("contention_count", n, 6);
    chk("contention_cycles", last, 17);
    @(negedge clock);

    // Misaligned store is dropped
    dm_we = 1'b1; dm_addr = 32'h22; dm_wdata = 32'h55; dm_req = 1'b1;
    exp_q.push_back(exp_t'{1'b1, 32'h0, 1'b1, 1'b0});
    @(negedge clock);
    chk("mis_ready", {dm_ready, err_misaligned, mem_req}, {1'b1, 1'b1, 1'b0});
    dm_req = 1'b0;
    @(negedge clock);
    chk("mis_no_write", {mem_req, mem[8]}, {1'b0, 32'hAB});

    // Watchdog timeout, then a late ack
    ack_auto = 1'b0;
    dm_we = 1'b0; dm_addr = 32'h40; dm_req = 1'b1;
    exp_q.push_back(exp_t'{1'b1, 32'hDEADBEEF, 1'b0, 1'b1});
    cnt = 0; seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clock);
      if (dm_ready) seen = 1'b1;
      else if (mem_req) cnt++;
    end
    dm_req = 1'b0;
    chk("to_memreq_cycles", {seen, 8'(cnt)}, {1'b1, 8'd8});
    repeat (2) @(negedge clock);
    ack_force = 1'b1;
    @(negedge clock);
    ack_force = 1'b0;
    repeat (3) @(negedge clock);
    chk("late_ack_ignored", {mem_req, if_ready, dm_ready, dm_rdata}, {1'b0, 1'b0, 1'b0, 32'hDEADBEEF});
    ack_auto = 1'b1;

    // Reset on the same edge as ack while BUSY
    ack_auto = 1'b0;
    if_addr = 32'h10; if_req = 1'b1;
    @(negedge clock);
    chk("rst_busy", {mem_req, mem_addr}, {1'b1, 10'd4});
    reset_n = 1'b0; ack_force = 1'b1;
    @(negedge clock);
    chk("rst_ctl", {if_ready, dm_ready, mem_req, mem_we, mem_addr, err_misaligned, err_timeout}, 128'h0);
    chk("rst_data", {mem_wdata, if_rdata, dm_rdata}, 128'h0);
    reset_n = 1'b1; ack_force = 1'b0; ack_auto = 1'b1;
    exp_q.push_back(exp_t'{1'b0, 32'h8C010004, 1'b0, 1'b0});
    wait_ready(1'b0, cyc);
    if_req = 1'b0;
    chk("reissue_latency", cyc, 2);

    repeat (3) @(negedge clock);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified word memory between the pipeline's instruction-fetch port (IF) and data-access port (MEM stage: LW/SW).
- Registers each granted request, drives a req/ack memory handshake, and returns read data to the winner with a one-cycle ready pulse.
- Provides the pipeline stall signal.
- Contains a starvation guard for IF, a memory watchdog, and misaligned-address rejection.

Parameters:
- ADDR_W, 10, word-address width of the backing memory (1024 words).
- STARVE_LIMIT, 4, number of consecutive data grants won against a pending IF request before IF is forced to win; 0 = strict data priority. Valid range 0..15.
- TIMEOUT, 255, maximum cycles spent in BUSY before the access is aborted; 0 = watchdog disabled. Valid range 0..255.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  synchronous active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetched word; valid while if_ready=1.
- if_ready  out  1  one-cycle completion pulse to IF.
- dm_req  in  1  data request; held with dm_we, dm_addr and dm_wdata until dm_ready.
- dm_we  in  1  1 = store (SW), 0 = load (LW).
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data.
- dm_rdata  out  32  load data; valid while dm_ready=1.
- dm_ready  out  1  one-cycle completion pulse to MEM.
- stall  out  1  combinational: (if_req & ~if_ready) | (dm_req & ~dm_ready).
- mem_req  out  1  memory request, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  word address = latched byte address bits [ADDR_W+1:2]; upper bits are ignored (address wraps modulo 2^ADDR_W words).
- mem_wdata  out  32  memory write data, registered.
- mem_ack  in  1  memory completion; sampled only while mem_req=1.
- mem_rdata  in  32  read data; valid with mem_ack.
- err_misaligned  out  1  one-cycle pulse, coincident with ready, when the served address has bits [1:0] != 0.
- err_timeout  out  1  one-cycle pulse, coincident with ready, when the watchdog aborts an access.

Behaviour:
- Reset (reset_n=0 at a clock edge, any state): the following all go to 0 — state=IDLE, mem_req, mem_we, mem_addr, mem_wdata, if_ready, dm_ready, if_rdata, dm_rdata, both err outputs, streak counter and watchdog counter. Reset wins over every simultaneous event, including mem_ack. An abandoned memory access is never completed to a requester.
- FSM states: IDLE, BUSY, RESP.
- IDLE, no request: remain IDLE; mem_req=0.
- IDLE, request present, winner selection:
  - Only one request pending: that requester wins.
  - Both pending: DM wins, unless STARVE_LIMIT != 0 and streak == STARVE_LIMIT, in which case IF wins.
- IDLE, winner has aligned address:
  - Latch winner id, address, we and wdata (IF always reads).
  - Next cycle: mem_req=1; state -> BUSY; watchdog cleared.
- IDLE, winner has misaligned address:
  - No memory access; a store is dropped.
  - State -> RESP with rdata=0 and err_misaligned=1.
- Streak counter:
  - DM grant while if_req=1: streak+1, saturating at 15.
  - IF grant, or DM grant while if_req=0: streak cleared.
- BUSY: mem_req, mem_we, mem_addr and mem_wdata held stable. Watchdog increments each cycle.
  - mem_ack=1 at an edge: capture mem_rdata into the winner's rdata (0 for a store); mem_req=0; state -> RESP.
  - Watchdog reaches TIMEOUT with no ack (TIMEOUT != 0): mem_req=0; rdata=32'hDEADBEEF; err_timeout=1; state -> RESP.
  - mem_ack arriving on the same edge the watchdog expires: ack wins.
- RESP (exactly one cycle): winner's ready=1, and any err pulse is asserted. Requests are not sampled. State -> IDLE.
- Ready, err and mem_req are all 0 outside their defined states.
- rdata registers hold their value until the next completion to the same port.
- Minimum latency with zero-wait memory: request sampled in IDLE at cycle 0, mem_req in cycle 1, ack in cycle 1, ready in cycle 2. Back-to-back accesses repeat every 3 cycles.
- A mem_ack received while mem_req=0 (late ack after a timeout or reset) is ignored.
- A requester may keep req high after its ready pulse. It is then re-arbitrated in the next IDLE cycle using the values on its inputs at that time.
- Dropping req before ready is illegal. Behaviour is undefined and not checked.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x10, memory acks on the first mem_req cycle with 0x8C010004 -> mem_addr=4; if_ready pulses in cycle 2 with if_rdata=0x8C010004; stall=1 in cycles 0-1.
- Store then load: dm_req SW addr=0x20 wdata=0xAB -> mem_we=1, mem_addr=8. Then LW addr=0x20 -> dm_rdata=0xAB; dm_ready pulses once per access.
- Contention and starvation (STARVE_LIMIT=4): if_req and dm_req held high continuously -> grant order DM,DM,DM,DM,IF,DM...; if_ready is first seen on the 5th completion.
- Misaligned: dm_req SW addr=0x22 -> mem_req never rises; dm_ready and err_misaligned pulse together 1 cycle after the IDLE sample; dm_rdata=0.
- Timeout (TIMEOUT=8): memory never acks -> mem_req stays high 8 cycles then falls; dm_ready with dm_rdata=0xDEADBEEF and err_timeout=1. A mem_ack injected 2 cycles later causes no ready pulse.
- Reset mid-BUSY: reset_n=0 on the same edge as mem_ack -> all outputs 0, state IDLE, no ready pulse. The request is reissued after reset_n=1.
